// File: rtl/vga_ctrl.sv
// VGA read-side controller: raster timing generator that addresses the frame buffer
// and registers the returned pixel together with matching hsync/vsync/valid.
module vga_ctrl #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Enable,
    input  logic [23:0] vga_data,
    output logic [9:0]  h_addr,
    output logic [8:0]  v_addr,
    output logic        hsync,
    output logic        vsync,
    output logic        valid,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        FrameStart
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             valid_q, valid_d;
    logic [23:0]      rgb_q, rgb_d;
    logic             fstart_q, fstart_d;

    logic pix_en, h_wrap, v_wrap, active, in_hsync, in_vsync;

    assign pix_en   = (div_cnt_q == DIV_LAST);
    assign h_wrap   = (h_cnt_q == H_LAST);
    assign v_wrap   = (v_cnt_q == V_LAST);
    assign active   = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign in_hsync = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    assign in_vsync = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);

    // Frame buffer is async-read: vga_data answers these addresses in the same cycle.
    assign h_addr = active ? h_cnt_q : 10'd0;
    assign v_addr = active ? v_cnt_q[8:0] : 9'd0;

    always_comb begin
        div_cnt_d = div_cnt_q;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        valid_d   = valid_q;
        rgb_d     = rgb_q;
        fstart_d  = 1'b0;
        if (!Enable) begin
            div_cnt_d = '0;
            h_cnt_d   = '0;
            v_cnt_d   = '0;
            hsync_d   = 1'b1;
            vsync_d   = 1'b1;
            valid_d   = 1'b0;
            rgb_d     = '0;
        end else if (pix_en) begin
            div_cnt_d = '0;
            // Output stage uses the pre-increment position, giving one pixel of latency.
            valid_d   = active;
            hsync_d   = ~in_hsync;
            vsync_d   = ~in_vsync;
            rgb_d     = active ? vga_data : 24'h0;
            if (h_wrap) begin
                h_cnt_d = '0;
                v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
                fstart_d = v_wrap;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            div_cnt_q <= '0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            valid_q   <= 1'b0;
            rgb_q     <= '0;
            fstart_q  <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            valid_q   <= valid_d;
            rgb_q     <= rgb_d;
            fstart_q  <= fstart_d;
        end
    end

    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign valid      = valid_q;
    assign vga_r      = rgb_q[23:16];
    assign vga_g      = rgb_q[15:8];
    assign vga_b      = rgb_q[7:0];
    assign FrameStart = fstart_q;
endmodule
